// File: rtl/semaforo_ctrl_if.sv
// Board-side signal bundle for semaforo_ctrl: button/switch inputs and lamp outputs.
interface semaforo_ctrl_if;
  logic       bt;
  logic       noite;
  logic [2:0] A;
  logic [2:0] B;
  logic       walk;
  logic       ped_wait;

  modport master (output bt, output noite, input A, input B, input walk, input ped_wait);
  modport slave  (input bt, input noite, output A, output B, output walk, output ped_wait);
endinterface

// File: rtl/semaforo_ctrl.sv
// Two-approach traffic-light controller with pedestrian walk phase and
// night-mode yellow flashing; lamps are decoded from state into registers.
module semaforo_ctrl #(
  parameter int unsigned W          = 8,
  parameter int unsigned T_VERDE_A  = 1,
  parameter int unsigned T_VERDE_B  = 1,
  parameter int unsigned T_AMARELO  = 3,
  parameter int unsigned T_VERMELHO = 2,
  parameter int unsigned T_PED      = 4,
  parameter int unsigned T_FLASH    = 1
) (
  input  logic           clk,
  input  logic           rst,
  semaforo_ctrl_if.slave bus
);

  localparam int unsigned LAMP_W = 7;

  localparam logic [W-1:0] L_VA   = W'(T_VERDE_A - 1);
  localparam logic [W-1:0] L_VB   = W'(T_VERDE_B - 1);
  localparam logic [W-1:0] L_AM   = W'(T_AMARELO - 1);
  localparam logic [W-1:0] L_VM   = W'(T_VERMELHO - 1);
  localparam logic [W-1:0] L_PED  = W'(T_PED - 1);
  localparam logic [W-1:0] L_FL   = W'(T_FLASH - 1);

  typedef enum logic [3:0] {
    S_A_VERDE  = 4'd0,
    S_A_AMAR   = 4'd1,
    S_VERM1    = 4'd2,
    S_B_VERDE  = 4'd3,
    S_B_AMAR   = 4'd4,
    S_VERM2    = 4'd5,
    S_PED      = 4'd6,
    S_PISCA_ON = 4'd7,
    S_PISCA_OFF = 4'd8
  } state_e;

  state_e              state_q, state_d;
  state_e              ret_q, ret_d;
  logic [W-1:0]        cnt_q, cnt_d;
  logic                req_q, req_d;
  logic [LAMP_W-1:0]   lamps_q;

  // Counter reload value for the phase being entered.
  function automatic logic [W-1:0] load_f(input state_e s);
    case (s)
      S_A_VERDE:               load_f = L_VA;
      S_B_VERDE:               load_f = L_VB;
      S_A_AMAR, S_B_AMAR:      load_f = L_AM;
      S_VERM1, S_VERM2:        load_f = L_VM;
      S_PED:                   load_f = L_PED;
      S_PISCA_ON, S_PISCA_OFF: load_f = L_FL;
      default:                 load_f = L_VA;
    endcase
  endfunction

  // Lamp pattern {A[2:0], B[2:0], walk} for a state.
  function automatic logic [LAMP_W-1:0] lamps_f(input state_e s);
    case (s)
      S_A_VERDE:   lamps_f = 7'b001_100_0;
      S_A_AMAR:    lamps_f = 7'b010_100_0;
      S_VERM1:     lamps_f = 7'b100_100_0;
      S_B_VERDE:   lamps_f = 7'b100_001_0;
      S_B_AMAR:    lamps_f = 7'b100_010_0;
      S_VERM2:     lamps_f = 7'b100_100_0;
      S_PED:       lamps_f = 7'b100_100_1;
      S_PISCA_ON:  lamps_f = 7'b010_010_0;
      S_PISCA_OFF: lamps_f = 7'b000_000_0;
      default:     lamps_f = 7'b001_100_0;
    endcase
  endfunction

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_A_VERDE;
      cnt_q   <= L_VA;
      req_q   <= 1'b0;
      ret_q   <= S_B_VERDE;
      lamps_q <= 7'b001_100_0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      req_q   <= req_d;
      ret_q   <= ret_d;
      lamps_q <= lamps_f(state_d);
    end
  end

  state_e nxt;
  state_e ret_n;
  logic   legal;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    req_d   = req_q;
    ret_d   = ret_q;
    nxt     = S_A_VERDE;
    ret_n   = ret_q;
    legal   = 1'b1;

    // Successor if the current phase expires now; night beats walk beats ring.
    case (state_q)
      S_A_VERDE:  nxt = S_A_AMAR;
      S_A_AMAR:   nxt = S_VERM1;
      S_B_VERDE:  nxt = S_B_AMAR;
      S_B_AMAR:   nxt = S_VERM2;
      S_VERM1: begin
        if (bus.noite)             nxt = S_PISCA_ON;
        else if (req_q || bus.bt) begin
          nxt   = S_PED;
          ret_n = S_B_VERDE;
        end else                   nxt = S_B_VERDE;
      end
      S_VERM2: begin
        if (bus.noite)             nxt = S_PISCA_ON;
        else if (req_q || bus.bt) begin
          nxt   = S_PED;
          ret_n = S_A_VERDE;
        end else                   nxt = S_A_VERDE;
      end
      S_PED:       nxt = ret_q;
      S_PISCA_ON:  nxt = S_PISCA_OFF;
      S_PISCA_OFF: nxt = bus.noite ? S_PISCA_ON : S_VERM2;
      default: begin
        nxt   = S_A_VERDE;
        legal = 1'b0;
      end
    endcase

    if (!legal || (cnt_q == '0)) begin
      state_d = nxt;
      cnt_d   = load_f(nxt);
      if (nxt == S_PED) ret_d = ret_n;
    end else begin
      cnt_d = cnt_q - W'(1);
    end

    // Request latches outside PED and is consumed on PED entry.
    if ((state_d == S_PED) && (state_q != S_PED)) req_d = 1'b0;
    else if (bus.bt && (state_q != S_PED))          req_d = 1'b1;
  end

  assign bus.A        = lamps_q[6:4];
  assign bus.B        = lamps_q[3:1];
  assign bus.walk     = lamps_q[0];
  assign bus.ped_wait = req_q;

endmodule

// File: doc/semaforo_ctrl.md
Name: semaforo_ctrl

Overview:
- Parametrised two-approach traffic-light controller; next generation of `semaforo`.
- Per-approach green times and a configurable all-red clearance.
- Latched pedestrian request that inserts a walk phase.
- Night mode that flashes yellow on both approaches.
- Sits between the board button/switch inputs and the lamp drivers.

Parameters:
- W, 8, width of the phase down-counter.
- T_VERDE_A, 1, cycles approach A stays green (1..2^W-1).
- T_VERDE_B, 1, cycles approach B stays green (1..2^W-1).
- T_AMARELO, 3, cycles of yellow on either approach (1..2^W-1).
- T_VERMELHO, 2, all-red clearance cycles (1..2^W-1).
- T_PED, 4, pedestrian walk cycles (1..2^W-1).
- T_FLASH, 1, night-mode half-period in cycles (1..2^W-1).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset; asynchronous, active-low.
- bt  in  1  pedestrian button, level, synchronous to clk.
- noite  in  1  night-mode request, level, synchronous to clk.
- A  out  3  approach A lamps: [2]=red, [1]=yellow, [0]=green.
- B  out  3  approach B lamps, same encoding as A.
- walk  out  1  pedestrian walk lamp.
- ped_wait  out  1  pedestrian request pending.

Behaviour:
- States and lamps (A / B / walk):
  - A_VERDE: 001 / 100 / 0
  - A_AMAR: 010 / 100 / 0
  - VERM1: 100 / 100 / 0
  - B_VERDE: 100 / 001 / 0
  - B_AMAR: 100 / 010 / 0
  - VERM2: 100 / 100 / 0
  - PED: 100 / 100 / 1
  - PISCA_ON: 010 / 010 / 0
  - PISCA_OFF: 000 / 000 / 0
- Outputs are Moore, decoded from the registered state only; no combinational path from bt or noite to any output.
- Reset (rst=0, asynchronous):
  - State = A_VERDE, counter = T_VERDE_A-1.
  - req = 0, ret = B_VERDE.
  - Outputs: A=001, B=100, walk=0, ped_wait=0.
- Timing:
  - On entering a state, the counter loads T_state-1.
  - Each rising edge: if counter != 0, decrement; else take the transition.
  - Every state therefore lasts exactly T_state cycles.
- Normal ring: A_VERDE -> A_AMAR -> VERM1 -> B_VERDE -> B_AMAR -> VERM2 -> A_VERDE.
- Pedestrian request:
  - req sets on any edge with bt=1 while the state is not PED. It is sticky; ped_wait = req.
  - At expiry of VERM1 or VERM2, if (req | bt), go to PED instead of the next green.
  - ret records that next green: B_VERDE after VERM1, A_VERDE after VERM2.
  - req clears on the edge entering PED. bt while in PED is ignored and does not re-set req.
  - At PED expiry, go to ret.
- Night mode:
  - Checked only at expiry of VERM1 or VERM2. Sampled noite=1 there has priority over the pedestrian request: go to PISCA_ON.
  - Flash cycle: PISCA_ON -> PISCA_OFF -> PISCA_ON, each lasting T_FLASH cycles.
  - Exit is checked only at PISCA_OFF expiry: if noite=0, go to VERM2 (full T_VERMELHO), which then proceeds normally.
  - req may still be set during night mode and stays pending. It is serviced at that VERM2 expiry, with ret = A_VERDE.
  - noite toggling at any other time has no effect until the next check point.
- Simultaneous events at a VERM expiry: noite wins over req, and req wins over the normal ring.
- A green or yellow is never cut short; no state is skipped.
- Reset mid-phase: immediate return to reset values, and any pending req is lost.
- Counter arithmetic is unsigned W bits with no wrap: it reloads before underflow.
- Illegal state encodings decode to A_VERDE with counter = T_VERDE_A-1 on the next edge.

Test Plan (defaults):
1. Release rst after 1 cycle, bt=0, noite=0 -> period is 12 cycles.
   - A=001 for 1 cycle, A=010 for 3, then both 100 for 2.
   - B=001 for 1, B=010 for 3, then both 100 for 2; repeat.
2. bt pulsed for 1 cycle during A_AMAR -> ped_wait=1 on the next cycle.
   - After VERM1: walk=1 with both red for 4 cycles, and ped_wait drops on PED entry.
   - Then B_VERDE follows.
3. bt=1 only in the last VERM2 cycle -> PED entered directly, lasting 4 cycles, then A_VERDE. ped_wait never observed high.
4. bt held high across the whole PED phase -> exactly one PED phase, ped_wait=0 after PED.
   - bt held beyond PED re-sets req, giving the next PED after the following VERM.
5. noite=1 asserted during B_VERDE -> lamps unchanged until VERM2 expiry, then A=B=010 / 000 alternating every cycle.
   - Deassert noite -> after the next PISCA_OFF, both red for 2 cycles, then A=001.
   - bt pressed during night mode -> PED inserted after that VERM2.
6. rst pulled low mid-B_AMAR with req=1 -> asynchronously A=001, B=100, walk=0, ped_wait=0 without waiting for a clock edge.
7. Parameter override T_VERDE_A=5, T_PED=1, W=4 -> A green lasts 5 cycles and walk lasts 1 cycle.
